// File: rtl/alu_issue.sv
// Issue stage between decode and the combinational ALU: decodes ALUOp/funct,
// holds operands and control for the execute window, registers the ALU result.
module alu_issue #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  ALUOp_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  ALUCtrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        error_o,
    output logic        valid_o,
    input  logic        ready_i
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] CODE_IDLE = 3'b011;
    localparam logic [2:0] CODE_MUL  = 3'b111;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  code_q, code_d;
    logic        err_q, err_d;
    logic [31:0] d1_q, d1_d, d2_q, d2_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d, oerr_q, oerr_d;
    logic [2:0]  dec_code;
    logic        dec_err;

    always_comb begin
        dec_code = CODE_IDLE;
        dec_err  = 1'b0;
        unique case (ALUOp_i)
            2'b00: dec_code = 3'b010;
            2'b01: dec_code = 3'b110;
            2'b11: dec_code = 3'b001;
            default: begin
                case (funct_i)
                    6'b100000: dec_code = 3'b010;
                    6'b100010: dec_code = 3'b110;
                    6'b100100: dec_code = 3'b000;
                    6'b100101: dec_code = 3'b001;
                    6'b011000: dec_code = CODE_MUL;
                    default:   dec_err  = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        err_d   = err_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        res_d   = res_q;
        zero_d  = zero_q;
        oerr_d  = oerr_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    d1_d    = data1_i;
                    d2_d    = data2_i;
                    code_d  = dec_code;
                    err_d   = dec_err;
                    cnt_d   = (dec_code == CODE_MUL) ? 3'(MUL_CYCLES) : 3'd1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    res_d   = alu_result_i;
                    zero_d  = alu_zero_i;
                    oerr_d  = err_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            code_q  <= CODE_IDLE;
            err_q   <= 1'b0;
            d1_q    <= 32'd0;
            d2_q    <= 32'd0;
            res_q   <= 32'd0;
            zero_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            err_q   <= err_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            oerr_q  <= oerr_d;
        end
    end

    // Outside EXEC the ALU sees the idle code so its output stays at zero.
    assign ALUCtrl_o   = (state_q == S_EXEC) ? code_q : CODE_IDLE;
    assign alu_data1_o = d1_q;
    assign alu_data2_o = d2_q;
    assign ready_o     = (state_q == S_IDLE) && rst_i;
    assign valid_o     = (state_q == S_RESP);
    assign result_o    = res_q;
    assign zero_o      = zero_q;
    assign error_o     = oerr_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU on the alu_* ports, directed ops,
// scoreboard queue filled at issue and drained by an output monitor.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0, ready_i = 1'b1;
    logic        ready_o;
    logic [1:0]  ALUOp_i = 2'b00;
    logic [5:0]  funct_i = 6'd0;
    logic [31:0] data1_i = 32'd0, data2_i = 32'd0;
    logic [31:0] alu_d1, alu_d2, alu_res, result_o;
    logic [2:0]  ctrl;
    logic        alu_zero, zero_o, error_o, valid_o;

    logic        valid4 = 1'b0;
    logic        ready4_o, valid4_o, zero4_o, error4_o, alu_zero4;
    logic [31:0] alu4_d1, alu4_d2, alu4_res, result4_o;
    logic [2:0]  ctrl4;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] res; logic z; logic e; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return a * b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res   = alu_f(ctrl, alu_d1, alu_d2);
    assign alu_zero  = (alu_res == 32'd0);
    assign alu4_res  = alu_f(ctrl4, alu4_d1, alu4_d2);
    assign alu_zero4 = (alu4_res == 32'd0);

    alu_issue #(.MUL_CYCLES(2)) dut (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .ALUOp_i(ALUOp_i), .funct_i(funct_i), .data1_i(data1_i), .data2_i(data2_i),
        .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .ALUCtrl_o(ctrl),
        .alu_result_i(alu_res), .alu_zero_i(alu_zero),
        .result_o(result_o), .zero_o(zero_o), .error_o(error_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    alu_issue #(.MUL_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid4), .ready_o(ready4_o),
        .ALUOp_i(ALUOp_i), .funct_i(funct_i), .data1_i(data1_i), .data2_i(data2_i),
        .alu_data1_o(alu4_d1), .alu_data2_o(alu4_d2), .ALUCtrl_o(ctrl4),
        .alu_result_i(alu4_res), .alu_zero_i(alu_zero4),
        .result_o(result4_o), .zero_o(zero4_o), .error_o(error4_o),
        .valid_o(valid4_o), .ready_i(1'b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result 0x%08h with empty scoreboard", result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", result_o, e.res);
                chk("sb_zero", {31'd0, zero_o}, {31'd0, e.z});
                chk("sb_error", {31'd0, error_o}, {31'd0, e.e});
            end
        end
    end

    // Waits for ready_o, presents one op and returns just after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic push, input logic [31:0] r,
                         input logic z, input logic e);
        int n = 0;
        while (!ready_o && n < 20) begin tick; n++; end
        if (!ready_o) chk("issue_ready_timeout", {31'd0, ready_o}, 32'd1);
        ALUOp_i = op; funct_i = fn; data1_i = a; data2_i = b; valid_i = 1'b1;
        if (push) sb.push_back('{res: r, z: z, e: e});
        tick;
        valid_i = 1'b0;
    endtask

    // Counts edges from the accept edge to the first cycle with valid_o high.
    task automatic wait_valid(input string name, input int exp_lat);
        int lat = 1;
        while (!valid_o && lat < 20) begin tick; lat++; end
        chk(name, lat, exp_lat);
    endtask

    initial begin
        ready_i = 1'b1;
        tick; tick;
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_ctrl", {29'd0, ctrl}, 32'd3);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_data1", alu_d1, 32'd0);
        chk("rst_flags", {30'd0, zero_o, error_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, ready_o}, 32'd1);

        // add via funct: 5+7
        issue(2'b10, 6'b100000, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0);
        chk("add_ctrl_T1", {29'd0, ctrl}, 32'b010);
        chk("add_op1_T1", alu_d1, 32'd5);
        wait_valid("add_latency", 2);
        chk("add_ctrl_T2", {29'd0, ctrl}, 32'b011);
        tick;
        chk("add_valid_drop", {31'd0, valid_o}, 32'd0);

        // sub via ALUOp 01 giving zero
        issue(2'b01, 6'd0, 32'd9, 32'd9, 1'b1, 32'd0, 1'b1, 1'b0);
        chk("sub_ctrl", {29'd0, ctrl}, 32'b110);
        wait_valid("sub_latency", 2);

        // remaining decode paths
        issue(2'b00, 6'd0, 32'd100, 32'd23, 1'b1, 32'd123, 1'b0, 1'b0);
        wait_valid("aluop00_latency", 2);
        issue(2'b11, 6'd0, 32'h0F00, 32'h00F0, 1'b1, 32'h0FF0, 1'b0, 1'b0);
        chk("or_ctrl", {29'd0, ctrl}, 32'b001);
        wait_valid("aluop11_latency", 2);
        issue(2'b10, 6'b100010, 32'd3, 32'd10, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0);
        wait_valid("funct_sub_latency", 2);
        issue(2'b10, 6'b100101, 32'hA000_0000, 32'h5, 1'b1, 32'hA000_0005, 1'b0, 1'b0);
        wait_valid("funct_or_latency", 2);

        // multiply, two-cycle window
        issue(2'b10, 6'b011000, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0, 1'b0);
        chk("mul_ctrl_T1", {29'd0, ctrl}, 32'b111);
        tick;
        chk("mul_ctrl_T2", {29'd0, ctrl}, 32'b111);
        chk("mul_valid_T2", {31'd0, valid_o}, 32'd0);
        tick;
        chk("mul_valid_T3", {31'd0, valid_o}, 32'd1);
        chk("mul_ctrl_T3", {29'd0, ctrl}, 32'b011);
        tick;

        // multiply on the four-cycle instance
        begin
            int lat = 1;
            ALUOp_i = 2'b10; funct_i = 6'b011000; data1_i = 32'd6; data2_i = 32'd7;
            chk("mul4_ready", {31'd0, ready4_o}, 32'd1);
            valid4 = 1'b1;
            tick;
            valid4 = 1'b0;
            while (!valid4_o && lat < 20) begin
                chk("mul4_ctrl", {29'd0, ctrl4}, 32'b111);
                tick; lat++;
            end
            chk("mul4_latency", lat, 5);
            chk("mul4_result", result4_o, 32'd42);
            chk("mul4_flags", {30'd0, zero4_o, error4_o}, 32'd0);
        end

        // backpressure: AND held while a new op waits
        ready_i = 1'b0;
        issue(2'b10, 6'b100100, 32'hF0F0, 32'h0FF0, 1'b1, 32'h00F0, 1'b0, 1'b0);
        wait_valid("and_latency", 2);
        ALUOp_i = 2'b00; funct_i = 6'd0; data1_i = 32'd1; data2_i = 32'd2; valid_i = 1'b1;
        sb.push_back('{res: 32'd3, z: 1'b0, e: 1'b0});
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("bp_valid", {31'd0, valid_o}, 32'd1);
            chk("bp_result", result_o, 32'h00F0);
            chk("bp_ready", {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        tick;
        chk("bp_idle_ready", {31'd0, ready_o}, 32'd1);
        tick;
        valid_i = 1'b0;
        chk("bp_new_ctrl", {29'd0, ctrl}, 32'b010);
        wait_valid("bp_new_latency", 2);

        // illegal funct
        issue(2'b10, 6'b000000, 32'd8, 32'd8, 1'b1, 32'd0, 1'b1, 1'b1);
        chk("ill_ctrl", {29'd0, ctrl}, 32'b011);
        wait_valid("ill_latency", 2);
        tick;

        // reset during a multiply aborts it
        issue(2'b10, 6'b011000, 32'd3, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick;
        chk("abort_valid", {31'd0, valid_o}, 32'd0);
        chk("abort_ctrl", {29'd0, ctrl}, 32'b011);
        chk("abort_ready", {31'd0, ready_o}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("abort_no_valid", {31'd0, valid_o}, 32'd0);
        end

        tick;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Sequential driver for the combinational ALU's control/operand interface. It accepts one operation per valid/ready handshake and decodes ALUOp/funct into the 3-bit ALU control code. It holds the operands and control code stable on the ALU inputs for the operation's execute window, then captures the ALU result and zero flag into an output register presented downstream with valid/ready. It sits between the decode stage and the ALU. Multiply gets a configurable multi-cycle window.

## Interface
- MUL_CYCLES, 2, cycles the ALU inputs are held for a multiply; legal range 1..4.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-low reset.
- valid_i  input  1  upstream operation valid.
- ready_o  output  1  block accepts an operation: (state==IDLE) && rst_i.
- ALUOp_i  input  2  operation class.
- funct_i  input  6  R-type function field.
- data1_i  input  32  operand 1.
- data2_i  input  32  operand 2.
- alu_data1_o  output  32  registered operand 1 to ALU.
- alu_data2_o  output  32  registered operand 2 to ALU.
- ALUCtrl_o  output  3  registered control code to ALU.
- alu_result_i  input  32  ALU data output.
- alu_zero_i  input  1  ALU zero flag.
- result_o  output  32  captured result.
- zero_o  output  1  captured zero flag.
- error_o  output  1  captured operation had an illegal funct.
- valid_o  output  1  result_o/zero_o/error_o valid.
- ready_i  input  1  downstream accepts result.

## Operation
- Decode:
  - ALUOp 00 -> 010 (add).
  - ALUOp 01 -> 110 (sub).
  - ALUOp 11 -> 001 (or).
  - ALUOp 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 011000 -> 111 (mul). Any other funct -> 011 with the error flag set.
- Idle code is 011. ALUCtrl_o carries it in every state except EXEC, so the ALU outputs 0.
- States:
  - IDLE: ready_o=1. On valid_i&&ready_o: register operands, decoded code and error flag; load cnt = (code==111) ? MUL_CYCLES : 1; go to EXEC.
  - EXEC: drive the registered code. Each cycle cnt decrements. When cnt==1: capture alu_result_i, alu_zero_i and error flag into the output register, then go to RESP.
  - RESP: valid_o=1. Outputs are held stable until ready_i. On ready_i go to IDLE; valid_o drops the next cycle.
- valid_i is ignored outside IDLE. ready_i is ignored outside RESP.
- alu_data1_o/alu_data2_o hold their last captured values outside EXEC.
- Width rules:
  - No arithmetic is performed in this block; result_o is the ALU's 32-bit result verbatim (mul is the low 32 bits).
  - cnt is 3 bits.
  - A MUL_CYCLES value outside 1..4 is a configuration error; behaviour is undefined.

## Timing
- Reset (rst_i=0 at an edge), values from the next cycle:
  - state=IDLE, cnt=0.
  - ALUCtrl_o=011.
  - alu_data1_o=alu_data2_o=0.
  - result_o=0, zero_o=0, error_o=0, valid_o=0.
  - ready_o=0 while rst_i=0.
- Reset mid-EXEC or mid-RESP aborts the operation; no result is presented.
- Handshake accepted at edge T:
  - ALUCtrl_o and operands are valid from T+1.
  - Non-mul: result is captured at edge T+2; valid_o=1 from T+2.
  - Mul: ALUCtrl_o=111 for exactly MUL_CYCLES cycles; valid_o from T+1+MUL_CYCLES.
- RESP with ready_i=1 at edge R: IDLE from R+1, so the next accept can occur at edge R+1.
- Back-to-back non-mul throughput: one operation per 3 cycles with ready_i held high.
- An illegal op takes the non-mul latency; it returns result 0, zero 1, error 1.

## Test plan
- Bench instantiates the existing ALU wired to the alu_* ports.
- Add: ALUOp 10, funct 100000, 5+7 accepted at T -> valid_o at T+2, result_o=12, zero_o=0, error_o=0; ALUCtrl_o=010 only during cycle T+1.
- Sub zero: ALUOp 01, 9 and 9 -> result_o=0, zero_o=1, valid_o at T+2.
- Mul, MUL_CYCLES=2: funct 011000, 6 and 7 -> ALUCtrl_o=111 for cycles T+1..T+2, valid_o at T+3, result_o=42; repeat with MUL_CYCLES=4 -> valid_o at T+5.
- Backpressure: complete an AND of 0xF0F0 and 0x0FF0, hold ready_i=0 for 3 cycles with valid_i=1 and new operands -> result_o=0x00F0 held, ready_o=0, new op not taken; ready_i=1 -> IDLE next cycle, new op accepted.
- Illegal: ALUOp 10, funct 000000 -> ALUCtrl_o=011 during EXEC, result_o=0, zero_o=1, error_o=1.
- Reset mid-op: accept a mul, assert rst_i=0 at T+1 -> from T+2 valid_o=0, ALUCtrl_o=011, and valid_o never rises for that op.
